minmax_window_tracker: RTL and testbench

- Parametrised successor to the team's streaming min/max tracker.
- Tracks running minimum and maximum of a WIDTH-bit sample stream qualified by a valid strobe.
- Closes a result window every WINDOW accepted samples, emits a one-cycle result pulse, and restarts with no dead cycles.
- Supports signed/unsigned compare and a synchronous clear. Split into a controller FSM and a compare/register datapath, as the existing block is.

---
 rtl/minmax_pkg.sv | 25 ++
 rtl/minmax_datapath.sv | 85 ++++++++
 rtl/minmax_window_tracker.sv | 92 +++++++++
 tb/tb_minmax_window_tracker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and helpers for the windowed min/max tracker.
// The compare helper works on CMP_W-bit operands; callers extend their samples to that width first.
package minmax_pkg;

  localparam int unsigned CMP_W = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned window);
    return $clog2(window + 1);
  endfunction

  function automatic logic less_than(input logic [CMP_W-1:0] a,
                                     input logic [CMP_W-1:0] b,
                                     input logic             signed_mode);
    if (signed_mode) begin
      return $signed(a) < $signed(b);
    end
    return a < b;
  endfunction

endpackage

// File: rtl/minmax_datapath.sv
// Running min/max registers, compare-select and the held window result.
// WIDTH is limited to minmax_pkg::CMP_W bits.
module minmax_datapath
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             load_first,
  input  logic             update,
  input  logic             commit,
  input  logic             clr_partial,
  output logic [WIDTH-1:0] run_min,
  output logic [WIDTH-1:0] run_max,
  output logic [WIDTH-1:0] res_min,
  output logic [WIDTH-1:0] res_max
);

  localparam logic SGN = (SIGNED != 0);

  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] res_min_q, res_min_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic [WIDTH-1:0] cand_min, cand_max;

  function automatic logic [CMP_W-1:0] widen(input logic [WIDTH-1:0] x);
    if (SGN) begin
      return CMP_W'(signed'(x));
    end
    return CMP_W'(x);
  endfunction

  // Candidate extremes including the incoming sample; ties keep the held value.
  always_comb begin
    cand_min = in_data;
    cand_max = in_data;
    if (!load_first) begin
      cand_min = less_than(widen(in_data), widen(run_min_q), SGN) ? in_data : run_min_q;
      cand_max = less_than(widen(run_max_q), widen(in_data), SGN) ? in_data : run_max_q;
    end
  end

  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
    if (clr_partial) begin
      run_min_d = '0;
      run_max_d = '0;
    end else if (commit) begin
      res_min_d = cand_min;
      res_max_d = cand_max;
      run_min_d = '0;
      run_max_d = '0;
    end else if (load_first || update) begin
      run_min_d = cand_min;
      run_max_d = cand_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min_q <= '0;
      run_max_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
    end
  end

  assign run_min = run_min_q;
  assign run_max = run_max_q;
  assign res_min = res_min_q;
  assign res_max = res_max_q;

endmodule

// File: rtl/minmax_window_tracker.sv
// Windowed streaming min/max tracker: controller FSM plus compare/register datapath.
// A window closes on the WINDOW-th accepted sample; the next window may start the following cycle.
module minmax_window_tracker
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         clear,
  output logic [WIDTH-1:0]             running_min,
  output logic [WIDTH-1:0]             running_max,
  output logic [cnt_w(WINDOW)-1:0]     sample_count,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_min,
  output logic [WIDTH-1:0]             out_max
);

  localparam int unsigned CNT_W = cnt_w(WINDOW);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             load_first, update, commit, clr_partial;
  logic             last_sample;

  assign last_sample = (count_q == CNT_W'(WINDOW - 1));

  // Next-state and datapath strobes; clear wins over a same-cycle sample.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_first  = 1'b0;
    update      = 1'b0;
    commit      = 1'b0;
    clr_partial = 1'b0;
    if (clear) begin
      state_d     = EMPTY;
      count_d     = '0;
      clr_partial = 1'b1;
    end else if (in_valid) begin
      load_first = (state_q == EMPTY);
      update     = (state_q == TRACK);
      if (last_sample) begin
        commit  = 1'b1;
        state_d = EMPTY;
        count_d = '0;
      end else begin
        state_d = TRACK;
        count_d = count_q + CNT_W'(1);
      end
    end
    out_valid_d = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  minmax_datapath #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .load_first  (load_first),
    .update      (update),
    .commit      (commit),
    .clr_partial (clr_partial),
    .run_min     (running_min),
    .run_max     (running_max),
    .res_min     (out_min),
    .res_max     (out_max)
  );

  assign sample_count = count_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_minmax_window_tracker.sv
// Scoreboard bench: an unsigned and a signed WINDOW=4 instance share one stimulus stream,
// a WINDOW=1 instance has its own; a forked monitor pops expected results on every out_valid.
module tb_minmax_window_tracker;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       a_valid, a_clear, b_valid, b_clear;
  logic [7:0] a_data, b_data;

  logic [7:0] u_rmin, u_rmax, u_omin, u_omax;
  logic [2:0] u_cnt;
  logic       u_ov;
  logic [7:0] s_rmin, s_rmax, s_omin, s_omax;
  logic [2:0] s_cnt;
  logic       s_ov;
  logic [7:0] w_rmin, w_rmax, w_omin, w_omax;
  logic [0:0] w_cnt;
  logic       w_ov;

  exp_t exp_u[$];
  exp_t exp_s[$];
  exp_t exp_w[$];
  int   pulse_cyc[$];
  int   n_tests;
  int   n_fail;

  minmax_window_tracker #(.WIDTH(8), .WINDOW(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .clear(a_clear),
    .running_min(u_rmin), .running_max(u_rmax), .sample_count(u_cnt),
    .out_valid(u_ov), .out_min(u_omin), .out_max(u_omax));

  minmax_window_tracker #(.WIDTH(8), .WINDOW(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .clear(a_clear),
    .running_min(s_rmin), .running_max(s_rmax), .sample_count(s_cnt),
    .out_valid(s_ov), .out_min(s_omin), .out_max(s_omax));

  minmax_window_tracker #(.WIDTH(8), .WINDOW(1), .SIGNED(0)) u_dut_w1 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .clear(b_clear),
    .running_min(w_rmin), .running_max(w_rmax), .sample_count(w_cnt),
    .out_valid(w_ov), .out_min(w_omin), .out_max(w_omax));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic c);
    a_valid = v;
    a_data  = d;
    a_clear = c;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic c);
    b_valid = v;
    b_data  = d;
    b_clear = c;
  endtask

  task automatic pop_check(input string name, input logic [7:0] mn, input logic [7:0] mx,
                           inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_pulse: got min=%0h max=%0h, expected no pulse", name, mn, mx);
    end else begin
      e = q.pop_front();
      chk({name, "_min"}, 32'(mn), 32'(e.mn));
      chk({name, "_max"}, 32'(mx), 32'(e.mx));
    end
  endtask

  // Four consecutive samples on group A; expectations pushed as the closing sample is issued.
  task automatic window4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input exp_t eu, input exp_t es);
    step(); drive_a(1'b1, d0, 1'b0);
    step(); drive_a(1'b1, d1, 1'b0);
    step(); drive_a(1'b1, d2, 1'b0);
    step(); drive_a(1'b1, d3, 1'b0);
    exp_u.push_back(eu);
    exp_s.push_back(es);
  endtask

  initial begin
    int base;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive_a(1'b1, 8'h55, 1'b0);
    drive_b(1'b1, 8'h55, 1'b0);

    fork
      begin : monitor
        int cyc;
        cyc = 0;
        forever begin
          @(negedge clk);
          cyc++;
          if (u_ov === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pop_check("u_pulse", u_omin, u_omax, exp_u);
          end
          if (s_ov === 1'b1) pop_check("s_pulse", s_omin, s_omax, exp_s);
          if (w_ov === 1'b1) pop_check("w_pulse", w_omin, w_omax, exp_w);
        end
      end
    join_none

    // Reset held for two edges with a sample present
    step(); step();
    chk("rst_rmin", 32'(u_rmin), 0);
    chk("rst_rmax", 32'(u_rmax), 0);
    chk("rst_cnt", 32'(u_cnt), 0);
    chk("rst_omin", 32'(u_omin), 0);
    chk("rst_omax", 32'(u_omax), 0);
    chk("rst_ov", 32'(u_ov), 0);
    chk("rst_w_omax", 32'(w_omax), 0);
    rst = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);

    // Unsigned window 5,200,3,7 (signed view: 200 = -56)
    step(); drive_a(1'b1, 8'd5, 1'b0);
    step(); drive_a(1'b1, 8'd200, 1'b0);
    step(); drive_a(1'b1, 8'd3, 1'b0);
    step();
    chk("t2_rmin3", 32'(u_rmin), 3);
    chk("t2_rmax3", 32'(u_rmax), 200);
    chk("t2_cnt3", 32'(u_cnt), 3);
    chk("t2_s_rmin3", 32'(s_rmin), 32'h0C8);
    chk("t2_s_rmax3", 32'(s_rmax), 5);
    drive_a(1'b1, 8'd7, 1'b0);
    exp_u.push_back('{mn: 8'd3, mx: 8'd200});
    exp_s.push_back('{mn: 8'hC8, mx: 8'h07});
    step();
    chk("t2_ov", 32'(u_ov), 1);
    chk("t2_cnt_wrap", 32'(u_cnt), 0);
    chk("t2_rmin_clr", 32'(u_rmin), 0);
    chk("t2_rmax_clr", 32'(u_rmax), 0);
    drive_a(1'b0, 8'h00, 1'b0);

    // Signed vs unsigned on the same samples
    window4(8'hF0, 8'h10, 8'h7F, 8'h80, '{mn: 8'h10, mx: 8'hF0}, '{mn: 8'h80, mx: 8'h7F});
    step(); drive_a(1'b0, 8'h00, 1'b0);
    step();

    // Back-to-back windows 1..8
    base = pulse_cyc.size();
    window4(8'd1, 8'd2, 8'd3, 8'd4, '{mn: 8'd1, mx: 8'd4}, '{mn: 8'd1, mx: 8'd4});
    window4(8'd5, 8'd6, 8'd7, 8'd8, '{mn: 8'd5, mx: 8'd8}, '{mn: 8'd5, mx: 8'd8});
    step(); drive_a(1'b0, 8'h00, 1'b0);
    step(); step();
    chk("t4_pulses", 32'(pulse_cyc.size() - base), 2);
    if (pulse_cyc.size() >= base + 2)
      chk("t4_spacing", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 4);

    // Clear discards partial window and its same-cycle sample
    step(); drive_a(1'b1, 8'd9, 1'b0);
    step(); drive_a(1'b1, 8'd2, 1'b0);
    step(); drive_a(1'b1, 8'd50, 1'b1);
    step();
    chk("t5_clr_cnt", 32'(u_cnt), 0);
    chk("t5_clr_rmin", 32'(u_rmin), 0);
    drive_a(1'b1, 8'd10, 1'b0);
    step(); drive_a(1'b1, 8'd11, 1'b0);
    step(); drive_a(1'b1, 8'd12, 1'b0);
    step(); drive_a(1'b1, 8'd13, 1'b0);
    exp_u.push_back('{mn: 8'd10, mx: 8'd13});
    exp_s.push_back('{mn: 8'd10, mx: 8'd13});
    step();
    chk("t5_ov", 32'(u_ov), 1);
    drive_a(1'b1, 8'd99, 1'b1);
    step();
    chk("t5_post_ov", 32'(u_ov), 0);
    chk("t5_hold_omin", 32'(u_omin), 10);
    chk("t5_hold_omax", 32'(u_omax), 13);
    chk("t5_post_cnt", 32'(u_cnt), 0);
    chk("t5_post_rmax", 32'(u_rmax), 0);
    drive_a(1'b0, 8'h00, 1'b0);

    // WINDOW=1: every sample is its own window
    step(); drive_b(1'b1, 8'd7, 1'b0);
    exp_w.push_back('{mn: 8'd7, mx: 8'd7});
    step();
    chk("t6_w_rmin", 32'(w_rmin), 0);
    chk("t6_w_cnt", 32'(w_cnt), 0);
    drive_b(1'b1, 8'd3, 1'b0);
    exp_w.push_back('{mn: 8'd3, mx: 8'd3});
    step();
    chk("t6_w_rmax", 32'(w_rmax), 0);
    rst = 1'b1;
    drive_b(1'b1, 8'd9, 1'b0);
    step();
    chk("t6_rst_omin", 32'(w_omin), 0);
    chk("t6_rst_omax", 32'(w_omax), 0);
    chk("t6_rst_ov", 32'(w_ov), 0);
    rst = 1'b0;
    drive_b(1'b0, 8'h00, 1'b0);

    repeat (6) step();
    chk("end_q_u", 32'(exp_u.size()), 0);
    chk("end_q_s", 32'(exp_s.size()), 0);
    chk("end_q_w", 32'(exp_w.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
